// File: rtl/axi_stream_gray_bram_writer.sv
// AXI4-Stream RGB -> 8-bit grayscale converter that packs one beat of gray pixels
// into a BRAM word and writes whole frames, strobing transfer_ready at frame end.
`timescale 1ns/1ps

module axi_stream_gray_bram_writer #(
  parameter int n             = 24,
  parameter int i             = 1,
  parameter int d             = 1,
  parameter int u             = 1,
  parameter int pixel_per_clk = 8,
  parameter int num_brams     = 1,
  parameter int addr_width    = 14,
  parameter int frame_words   = 9600
) (
  input  logic                                  ACLK,
  input  logic                                  rst,
  input  logic                                  s_TVALID,
  output logic                                  s_TREADY,
  input  logic [8*n-1:0]                        s_TDATA,
  input  logic [n-1:0]                          s_TSTRB,
  input  logic [n-1:0]                          s_TKEEP,
  input  logic                                  s_TLAST,
  input  logic [i-1:0]                          s_TID,
  input  logic [d-1:0]                          s_TDEST,
  input  logic [u-1:0]                          s_TUSER,
  output logic [num_brams-1:0]                  bram_we,
  output logic [num_brams*addr_width-1:0]       bram_addr,
  output logic [num_brams*8*pixel_per_clk-1:0]  bram_data_in,
  input  logic [num_brams*8*pixel_per_clk-1:0]  bram_data_out,
  output logic                                  transfer_ready,
  output logic                                  transfer_done
);

  localparam int WORD_W = 8 * pixel_per_clk;
  localparam int WPTR_W = (frame_words > 1) ? $clog2(frame_words) : 1;
  localparam int BANK_W = (num_brams > 1) ? $clog2(num_brams) : 1;
  localparam logic [WPTR_W-1:0] LAST_WPTR = WPTR_W'(frame_words - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(num_brams - 1);

  genvar gi;

  // Beat acceptance and frame position of the incoming beat
  logic                  accept;
  logic                  sof;
  logic                  frame_end;
  logic                  bank_wrap;
  logic [WPTR_W-1:0]     beat_wptr;
  logic [BANK_W-1:0]     beat_bank;
  logic [addr_width-1:0] beat_addr;

  logic [WPTR_W-1:0]     wptr_reg,  wptr_next;
  logic [BANK_W-1:0]     bank_reg,  bank_next;
  logic [addr_width-1:0] waddr_reg, waddr_next;

  // Stage 1: products plus the control that travels with them
  logic                  s1_valid_reg;
  logic                  s1_last_reg;
  logic [BANK_W-1:0]     s1_bank_reg;
  logic [addr_width-1:0] s1_addr_reg;
  logic [15:0]           prod_r_next [pixel_per_clk];
  logic [15:0]           prod_g_next [pixel_per_clk];
  logic [15:0]           prod_b_next [pixel_per_clk];
  logic [15:0]           prod_r_reg  [pixel_per_clk];
  logic [15:0]           prod_g_reg  [pixel_per_clk];
  logic [15:0]           prod_b_reg  [pixel_per_clk];

  // Stage 2 inputs
  logic [15:0]           lane_sum [pixel_per_clk];
  logic [WORD_W-1:0]     gray_word;
  logic [num_brams-1:0]  we_next;

  assign accept = s_TVALID & s_TREADY;
  assign sof    = s_TUSER[0];

  // A start-of-frame beat is placed at word 0 regardless of where the pointer was
  assign beat_wptr = sof ? '0 : wptr_reg;
  assign beat_bank = sof ? '0 : bank_reg;
  assign beat_addr = sof ? '0 : waddr_reg;

  assign frame_end = s_TLAST | (beat_wptr == LAST_WPTR);
  assign bank_wrap = (beat_bank == LAST_BANK);

  // Bank/address are kept as separate counters so no divider is needed for wptr
  always_comb begin
    wptr_next  = wptr_reg;
    bank_next  = bank_reg;
    waddr_next = waddr_reg;
    if (accept) begin
      if (frame_end) begin
        wptr_next  = '0;
        bank_next  = '0;
        waddr_next = '0;
      end else begin
        wptr_next = beat_wptr + WPTR_W'(1);
        if (bank_wrap) begin
          bank_next  = '0;
          waddr_next = beat_addr + addr_width'(1);
        end else begin
          bank_next  = beat_bank + BANK_W'(1);
          waddr_next = beat_addr;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (rst) begin
      s_TREADY     <= 1'b0;
      wptr_reg     <= '0;
      bank_reg     <= '0;
      waddr_reg    <= '0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_bank_reg  <= '0;
      s1_addr_reg  <= '0;
    end else begin
      s_TREADY     <= 1'b1;
      wptr_reg     <= wptr_next;
      bank_reg     <= bank_next;
      waddr_reg    <= waddr_next;
      s1_valid_reg <= accept;
      if (accept) begin
        s1_last_reg <= frame_end;
        s1_bank_reg <= beat_bank;
        s1_addr_reg <= beat_addr;
      end
    end
  end

  // One multiply-accumulate lane per pixel; coefficients sum to 256 so the
  // 16-bit total never overflows and its upper byte is the gray value.
  for (gi = 0; gi < pixel_per_clk; gi++) begin : g_lane
    logic [7:0] px_r, px_g, px_b;
    assign px_r = s_TDATA[24*gi      +: 8];
    assign px_g = s_TDATA[24*gi + 8  +: 8];
    assign px_b = s_TDATA[24*gi + 16 +: 8];

    assign prod_r_next[gi] = {8'd0, px_r} * 16'd77;
    assign prod_g_next[gi] = {8'd0, px_g} * 16'd150;
    assign prod_b_next[gi] = {8'd0, px_b} * 16'd29;

    assign lane_sum[gi]            = prod_r_reg[gi] + prod_g_reg[gi] + prod_b_reg[gi];
    assign gray_word[8*gi +: 8]    = lane_sum[gi][15:8];
  end

  // Product registers need no reset: they are only observed behind s1_valid_reg
  always_ff @(posedge ACLK) begin
    if (accept) begin
      prod_r_reg <= prod_r_next;
      prod_g_reg <= prod_g_next;
      prod_b_reg <= prod_b_next;
    end
  end

  for (gi = 0; gi < num_brams; gi++) begin : g_bank
    assign we_next[gi] = s1_valid_reg & (s1_bank_reg == BANK_W'(gi));
  end

  // Unselected banks see the same address/data; only their write enable differs
  always_ff @(posedge ACLK) begin
    if (rst) begin
      bram_we        <= '0;
      bram_addr      <= '0;
      bram_data_in   <= '0;
      transfer_ready <= 1'b0;
      transfer_done  <= 1'b0;
    end else begin
      bram_we        <= we_next;
      transfer_ready <= s1_valid_reg & s1_last_reg;
      if (s1_valid_reg) begin
        bram_addr    <= {num_brams{s1_addr_reg}};
        bram_data_in <= {num_brams{gray_word}};
      end
      if (s1_valid_reg & s1_last_reg) begin
        transfer_done <= 1'b1;
      end else if (accept) begin
        transfer_done <= 1'b0;
      end
    end
  end

  // Sideband inputs and the BRAM read port have no function in this block
  logic unused_inputs;
  assign unused_inputs = ^{s_TSTRB, s_TKEEP, s_TID, s_TDEST, s_TUSER, bram_data_out};

endmodule

// File: tb/tb_axi_stream_gray_bram_writer.sv
// Self-checking bench for axi_stream_gray_bram_writer: vector table, long frames,
// gapped and random streams, and mid-frame reset against a queue-based model.
`timescale 1ns/1ps

module tb_axi_stream_gray_bram_writer;

  localparam int FW = 9600;

  logic          ACLK = 1'b0;
  logic          rst  = 1'b1;
  logic          s_TVALID = 1'b0;
  logic          s_TREADY;
  logic [191:0]  s_TDATA = '0;
  logic [23:0]   s_TSTRB = '1;
  logic [23:0]   s_TKEEP = '1;
  logic          s_TLAST = 1'b0;
  logic [0:0]    s_TID = '0;
  logic [0:0]    s_TDEST = '0;
  logic [0:0]    s_TUSER = '0;
  logic [0:0]    bram_we;
  logic [13:0]   bram_addr;
  logic [63:0]   bram_data_in;
  logic [63:0]   bram_data_out = '0;
  logic          transfer_ready;
  logic          transfer_done;

  always #5 ACLK = ~ACLK;

  axi_stream_gray_bram_writer dut (
    .ACLK(ACLK), .rst(rst),
    .s_TVALID(s_TVALID), .s_TREADY(s_TREADY), .s_TDATA(s_TDATA),
    .s_TSTRB(s_TSTRB), .s_TKEEP(s_TKEEP), .s_TLAST(s_TLAST),
    .s_TID(s_TID), .s_TDEST(s_TDEST), .s_TUSER(s_TUSER),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_data_in(bram_data_in),
    .bram_data_out(bram_data_out),
    .transfer_ready(transfer_ready), .transfer_done(transfer_done)
  );

  typedef struct {
    int          due;
    int          addr;
    logic [63:0] word;
    logic        last;
  } wr_t;

  typedef struct {
    int          r0, g0, b0, rs, gs, bs;
    logic        user, last;
    logic [63:0] exp_word;
    int          exp_addr;
    logic        exp_ready;
  } vec_t;

  wr_t  q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_n   = 0;
  int   fptr     = 0;
  logic tready_exp = 1'b0;
  logic done_exp   = 1'b0;

  function automatic logic [63:0] gray_of(input logic [191:0] px);
    logic [63:0] w;
    int r, g, b;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      r = int'(px[24*k +: 8]);
      g = int'(px[24*k + 8 +: 8]);
      b = int'(px[24*k + 16 +: 8]);
      w[8*k +: 8] = 8'((77*r + 150*g + 29*b) / 256);
    end
    return w;
  endfunction

  function automatic logic [191:0] rand_px();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then check every output
  task automatic tick(input logic v, input logic [191:0] px, input logic last,
                      input logic user, input logic rst_in, input logic use_tab,
                      input logic [63:0] tab_word, input int tab_addr, input logic tab_ready);
    wr_t  w;
    logic acc, exp_we, exp_rdy;
    rst           = rst_in;
    s_TVALID      = v;
    s_TDATA       = px;
    s_TLAST       = last;
    s_TUSER       = user;
    bram_data_out = {$urandom(), $urandom()};
    acc = v && tready_exp && !rst_in;
    if (acc) begin
      if (user) fptr = 0;
      w.due  = edge_n + 2;
      w.addr = fptr;
      w.word = gray_of(px);
      w.last = last || (fptr == FW - 1);
      fptr   = w.last ? 0 : fptr + 1;
      if (use_tab) begin
        w.addr = tab_addr;
        w.word = tab_word;
        w.last = tab_ready;
      end
      q.push_back(w);
    end
    @(posedge ACLK);
    edge_n++;
    #1;
    if (rst_in) begin
      q.delete();
      done_exp   = 1'b0;
      fptr       = 0;
      tready_exp = 1'b0;
    end else begin
      tready_exp = 1'b1;
    end
    check("tready", 64'(s_TREADY), 64'(tready_exp));
    exp_we  = 1'b0;
    exp_rdy = 1'b0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      w       = q.pop_front();
      exp_we  = 1'b1;
      exp_rdy = w.last;
      check("addr", 64'(bram_addr), 64'(w.addr));
      check("data", bram_data_in, w.word);
    end
    check("we", 64'(bram_we), 64'(exp_we));
    check("transfer_ready", 64'(transfer_ready), 64'(exp_rdy));
    if (exp_rdy) done_exp = 1'b1;
    else if (acc) done_exp = 1'b0;
    check("transfer_done", 64'(transfer_done), 64'(done_exp));
    if (rst_in) begin
      check("reset_addr", 64'(bram_addr), 64'd0);
      check("reset_data", bram_data_in, 64'd0);
    end
  endtask

  task automatic beat(input logic v, input logic [191:0] px, input logic last, input logic user);
    tick(v, px, last, user, 1'b0, 1'b0, '0, 0, 1'b0);
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) beat(1'b0, rand_px(), 1'b0, 1'b0);
  endtask

  task automatic reset_for(input int cycles);
    for (int c = 0; c < cycles; c++) tick(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 0, 1'b0);
  endtask

  initial begin
    logic [191:0] px;
    int           start_fail;

    //         r0    g0    b0    rs  gs  bs  user  last  exp_word                 addr ready
    vecs[0] = '{255,  255,  255,  0,  0,  0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0};
    vecs[1] = '{0,    0,    0,   16,  0,  0, 1'b0, 1'b0, 64'h211C_1813_0E09_0400, 1, 1'b0};
    vecs[2] = '{0,    0,    0,    0, 16,  0, 1'b0, 1'b0, 64'h4138_2E25_1C12_0900, 2, 1'b0};
    vecs[3] = '{0,    0,    255,  0,  0,  0, 1'b0, 1'b0, 64'h1C1C_1C1C_1C1C_1C1C, 3, 1'b0};
    vecs[4] = '{16,   32,   48,   0,  0,  0, 1'b0, 1'b1, 64'h1D1D_1D1D_1D1D_1D1D, 4, 1'b1};
    vecs[5] = '{0,    0,    0,    0,  0,  0, 1'b1, 1'b0, 64'h0000_0000_0000_0000, 0, 1'b0};
    vecs[6] = '{255,  255,  255,  0,  0,  0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1};

    $display("reset: 10 cycles");
    reset_for(10);
    idle(1);

    for (int vi = 0; vi < 7; vi++) begin
      px = '0;
      for (int k = 0; k < 8; k++) begin
        px[24*k      +: 8] = 8'(vecs[vi].r0 + k * vecs[vi].rs);
        px[24*k + 8  +: 8] = 8'(vecs[vi].g0 + k * vecs[vi].gs);
        px[24*k + 16 +: 8] = 8'(vecs[vi].b0 + k * vecs[vi].bs);
      end
      start_fail = n_fail;
      tick(1'b1, px, vecs[vi].last, vecs[vi].user, 1'b0, 1'b1,
           vecs[vi].exp_word, vecs[vi].exp_addr, vecs[vi].exp_ready);
      $display("vec %0d: user=%0b last=%0b expect addr=%0d word=%h", vi,
               vecs[vi].user, vecs[vi].last, vecs[vi].exp_addr, vecs[vi].exp_word);
    end
    idle(4);

    $display("full frame: %0d back-to-back beats, TLAST on last", FW);
    for (int b = 0; b < FW; b++) beat(1'b1, rand_px(), b == FW - 1, b == 0);
    idle(6);
    beat(1'b1, rand_px(), 1'b0, 1'b1);
    idle(3);

    $display("gapped frame: valid every other cycle, auto-wrap at %0d words", FW);
    for (int b = 0; b < 2 * FW; b++) beat((b % 2) == 0, rand_px(), 1'b0, b == 0);
    for (int b = 0; b < 3; b++) beat(1'b1, rand_px(), 1'b0, 1'b0);
    idle(4);

    $display("random stream: 3000 cycles");
    for (int c = 0; c < 3000; c++)
      beat($urandom_range(3, 0) != 0, rand_px(), $urandom_range(149, 0) == 0,
           $urandom_range(199, 0) == 0);
    idle(4);

    $display("reset at beat 500, then new frame of 1000 beats");
    for (int b = 0; b < 500; b++) beat(1'b1, rand_px(), 1'b0, b == 0);
    reset_for(4);
    idle(4);
    for (int b = 0; b < 1000; b++) beat(1'b1, rand_px(), b == 999, b == 0);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
